vote_tally: RTL and testbench

Sequential, parametrised vote tallier for N voters. It registers a one-hot count of each ballot's yes votes and accumulates yes votes and ballot rounds across a voting session. A three-state session FSM (IDLE/OPEN/RESULT) controls accumulation and publishes a majority verdict when the session closes. It sits behind the voter input latches and feeds the result display/decoder logic.

---
 rtl/vote_tally.sv | 171 +++++++++++++++++
 tb/tb_vote_tally.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/vote_tally.sv
// vote_tally: session-based yes-vote accumulator with a majority verdict on close.
// Optional feature: define VOTE_TIE_EN to add the registered tie output.
module vote_tally #(
    parameter  int N_VOTERS = 3,
    parameter  int CNT_W    = 8,
    localparam int PC_W     = $clog2(N_VOTERS + 1),
    localparam int TOT_W    = CNT_W + PC_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [N_VOTERS-1:0] V,
    input  logic                v_valid,
    input  logic                close,
    output logic [N_VOTERS:0]   R,
    output logic [TOT_W-1:0]    yes_total,
    output logic [CNT_W-1:0]    rounds,
    output logic                busy,
    output logic                done,
    output logic                majority,
`ifdef VOTE_TIE_EN
    output logic                tie,
`endif
    output logic                ovf
);

    localparam int CMP_W = TOT_W + 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OPEN   = 2'd1,
        RESULT = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [N_VOTERS:0]   r_reg;
    logic [TOT_W-1:0]    yes_reg;
    logic [CNT_W-1:0]    rounds_reg;
    logic                majority_reg;
    logic                ovf_reg;

    logic [PC_W-1:0]     pop_count;
    logic [N_VOTERS:0]   pop_onehot;
    logic                in_open;
    logic                rounds_full;
    logic                accept;
    logic                reject;
    logic                closing;
    logic [TOT_W-1:0]    yes_next;
    logic [CNT_W-1:0]    rounds_next;
    logic [CMP_W-1:0]    cmp_lhs;
    logic [CMP_W-1:0]    cmp_rhs;

    // Ballot popcount and its one-hot decode
    always_comb begin
        pop_count = '0;
        for (int i = 0; i < N_VOTERS; i++) begin
            pop_count = pop_count + PC_W'(V[i]);
        end
    end

    generate
        for (genvar gi = 0; gi <= N_VOTERS; gi++) begin : g_onehot
            assign pop_onehot[gi] = (pop_count == PC_W'(gi));
        end
    endgenerate

    // start overrides any ballot or close arriving in the same cycle
    assign in_open     = (state_reg == OPEN);
    assign rounds_full = (rounds_reg == {CNT_W{1'b1}});
    assign accept      = in_open && v_valid && !start && !rounds_full;
    assign reject      = in_open && v_valid && !start && rounds_full;
    assign closing     = in_open && close && !start;

    // Totals including a ballot accepted in this cycle, so a close can count it
    assign yes_next    = accept ? (yes_reg + TOT_W'(pop_count)) : yes_reg;
    assign rounds_next = accept ? (rounds_reg + CNT_W'(1)) : rounds_reg;

    assign cmp_lhs = {1'b0, yes_next, 1'b0};
    assign cmp_rhs = CMP_W'(N_VOTERS) * CMP_W'(rounds_next);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) state_next = OPEN;
            end
            OPEN: begin
                if (start)      state_next = OPEN;
                else if (close) state_next = RESULT;
            end
            RESULT: begin
                if (start) state_next = OPEN;
            end
            default: state_next = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_reg)
            OPEN:    busy = 1'b1;
            RESULT:  done = 1'b1;
            default: ;
        endcase
    end

    // Accumulators and verdict
    always_ff @(posedge clk) begin
        if (rst) begin
            r_reg        <= '0;
            yes_reg      <= '0;
            rounds_reg   <= '0;
            majority_reg <= 1'b0;
            ovf_reg      <= 1'b0;
        end else if (start) begin
            r_reg        <= '0;
            yes_reg      <= '0;
            rounds_reg   <= '0;
            majority_reg <= 1'b0;
            ovf_reg      <= 1'b0;
        end else begin
            if (accept) begin
                r_reg      <= pop_onehot;
                yes_reg    <= yes_next;
                rounds_reg <= rounds_next;
            end
            if (reject) begin
                ovf_reg <= 1'b1;
            end
            if (closing) begin
                majority_reg <= (cmp_lhs > cmp_rhs);
            end
        end
    end

`ifdef VOTE_TIE_EN
    logic tie_reg;

    always_ff @(posedge clk) begin
        if (rst || start) begin
            tie_reg <= 1'b0;
        end else if (closing) begin
            tie_reg <= (cmp_lhs == cmp_rhs);
        end
    end

    assign tie = tie_reg;
`endif

    assign R         = r_reg;
    assign yes_total = yes_reg;
    assign rounds    = rounds_reg;
    assign majority  = majority_reg;
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_vote_tally.sv
// tb_vote_tally: directed sessions for vote_tally (N_VOTERS=3, CNT_W=4); expected
// outputs are queued by the driver and compared by an independent monitor.
module tb_vote_tally;

    localparam int N  = 3;
    localparam int CW = 4;
    localparam int TW = CW + $clog2(N + 1);

    typedef struct packed {
        logic [N:0]    r;
        logic [TW-1:0] yes;
        logic [CW-1:0] rnd;
        logic          busy;
        logic          done;
        logic          maj;
        logic          ovf;
        logic          tie;
    } exp_t;

    typedef struct {
        string nm;
        exp_t  e;
    } item_t;

    logic          clk;
    logic          rst;
    logic          start;
    logic [N-1:0]  v;
    logic          v_valid;
    logic          close;
    logic [N:0]    r;
    logic [TW-1:0] yes_total;
    logic [CW-1:0] rounds;
    logic          busy;
    logic          done;
    logic          majority;
    logic          ovf;
    logic          tie;

    item_t sb[$];
    int    n_checks = 0;
    int    n_errors = 0;

    vote_tally #(.N_VOTERS(N), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .V         (v),
        .v_valid   (v_valid),
        .close     (close),
        .R         (r),
        .yes_total (yes_total),
        .rounds    (rounds),
        .busy      (busy),
        .done      (done),
        .majority  (majority),
`ifdef VOTE_TIE_EN
        .tie       (tie),
`endif
        .ovf       (ovf)
    );

`ifndef VOTE_TIE_EN
    assign tie = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [N:0] er, input int ey, input int en,
                                input logic eb, input logic ed, input logic em,
                                input logic eo, input logic et);
        exp_t x;
        x.r    = er;
        x.yes  = TW'(ey);
        x.rnd  = CW'(en);
        x.busy = eb;
        x.done = ed;
        x.maj  = em;
        x.ovf  = eo;
`ifdef VOTE_TIE_EN
        x.tie  = et;
`else
        x.tie  = 1'b0;
`endif
        return x;
    endfunction

    // Drive one cycle of inputs and queue the outputs expected after that edge
    task automatic step(input string nm, input logic rs, input logic st, input logic vv,
                        input logic [N-1:0] vb, input logic cl, input exp_t e);
        item_t it;
        @(negedge clk);
        rst     = rs;
        start   = st;
        v_valid = vv;
        v       = vb;
        close   = cl;
        it.nm   = nm;
        it.e    = e;
        sb.push_back(it);
        @(posedge clk);
    endtask

    // Monitor: every edge that has a queued expectation is checked 1 time unit later
    always @(posedge clk) begin
        item_t it;
        exp_t  got;
        #1;
        if (sb.size() > 0) begin
            it       = sb.pop_front();
            got.r    = r;
            got.yes  = yes_total;
            got.rnd  = rounds;
            got.busy = busy;
            got.done = done;
            got.maj  = majority;
            got.ovf  = ovf;
            got.tie  = tie;
            n_checks = n_checks + 1;
            if (got !== it.e) begin
                n_errors = n_errors + 1;
                $display("FAIL %s: got R=%b yes=%0d rounds=%0d busy=%b done=%b maj=%b ovf=%b tie=%b, expected R=%b yes=%0d rounds=%0d busy=%b done=%b maj=%b ovf=%b tie=%b",
                         it.nm, got.r, got.yes, got.rnd, got.busy, got.done, got.maj, got.ovf, got.tie,
                         it.e.r, it.e.yes, it.e.rnd, it.e.busy, it.e.done, it.e.maj, it.e.ovf, it.e.tie);
            end else begin
                $display("ok   %s: R=%b yes=%0d rounds=%0d busy=%b done=%b maj=%b ovf=%b tie=%b",
                         it.nm, got.r, got.yes, got.rnd, got.busy, got.done, got.maj, got.ovf, got.tie);
            end
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; v_valid = 1'b0; v = '0; close = 1'b0;

        // Reset and ignored inputs in IDLE
        step("reset",      1, 0, 0, 3'b000, 0, mk(4'b0000, 0, 0, 0, 0, 0, 0, 0));
        step("idle_vv",    0, 0, 1, 3'b111, 0, mk(4'b0000, 0, 0, 0, 0, 0, 0, 0));
        step("idle_close", 0, 0, 0, 3'b000, 1, mk(4'b0000, 0, 0, 0, 0, 0, 0, 0));

        // Basic session: 111, 011, 000 -> 5 yes of 3 rounds, 10 > 9
        step("b_start",    0, 1, 0, 3'b000, 0, mk(4'b0000, 0, 0, 1, 0, 0, 0, 0));
        step("b_v111",     0, 0, 1, 3'b111, 0, mk(4'b1000, 3, 1, 1, 0, 0, 0, 0));
        step("b_v011",     0, 0, 1, 3'b011, 0, mk(4'b0100, 5, 2, 1, 0, 0, 0, 0));
        step("b_v000",     0, 0, 1, 3'b000, 0, mk(4'b0001, 5, 3, 1, 0, 0, 0, 0));
        step("b_close",    0, 0, 0, 3'b000, 1, mk(4'b0001, 5, 3, 0, 1, 1, 0, 0));
        step("res_vv",     0, 0, 1, 3'b111, 0, mk(4'b0001, 5, 3, 0, 1, 1, 0, 0));
        step("res_close",  0, 0, 0, 3'b000, 1, mk(4'b0001, 5, 3, 0, 1, 1, 0, 0));

        // Tie session: 011, 100 -> 6 == 6
        step("t_start",    0, 1, 0, 3'b000, 0, mk(4'b0000, 0, 0, 1, 0, 0, 0, 0));
        step("t_v011",     0, 0, 1, 3'b011, 0, mk(4'b0100, 2, 1, 1, 0, 0, 0, 0));
        step("t_v100",     0, 0, 1, 3'b100, 0, mk(4'b0010, 3, 2, 1, 0, 0, 0, 0));
        step("t_close",    0, 0, 0, 3'b000, 1, mk(4'b0010, 3, 2, 0, 1, 0, 0, 1));

        // Saturation: 15 accepted, 16th rejected with ovf
        step("s_start",    0, 1, 0, 3'b000, 0, mk(4'b0000, 0, 0, 1, 0, 0, 0, 0));
        for (int i = 1; i <= 15; i++) begin
            step($sformatf("s_v111_%0d", i), 0, 0, 1, 3'b111, 0, mk(4'b1000, 3 * i, i, 1, 0, 0, 0, 0));
        end
        step("s_v111_16",  0, 0, 1, 3'b111, 0, mk(4'b1000, 45, 15, 1, 0, 0, 1, 0));
        step("s_close",    0, 0, 0, 3'b000, 1, mk(4'b1000, 45, 15, 0, 1, 1, 1, 0));

        // Ballot in the close cycle is counted: 3 yes of 3 rounds, 6 > 9 false
        step("c_start",    0, 1, 0, 3'b000, 0, mk(4'b0000, 0, 0, 1, 0, 0, 0, 0));
        step("c_v000a",    0, 0, 1, 3'b000, 0, mk(4'b0001, 0, 1, 1, 0, 0, 0, 0));
        step("c_v000b",    0, 0, 1, 3'b000, 0, mk(4'b0001, 0, 2, 1, 0, 0, 0, 0));
        step("c_v111cl",   0, 0, 1, 3'b111, 1, mk(4'b1000, 3, 3, 0, 1, 0, 0, 0));

        // start beats a simultaneous ballot and close
        step("x_start",    0, 1, 0, 3'b000, 0, mk(4'b0000, 0, 0, 1, 0, 0, 0, 0));
        step("x_v111",     0, 0, 1, 3'b111, 0, mk(4'b1000, 3, 1, 1, 0, 0, 0, 0));
        step("x_st_vv",    0, 1, 1, 3'b111, 1, mk(4'b0000, 0, 0, 1, 0, 0, 0, 0));

        // Reset mid-session
        step("m_v011",     0, 0, 1, 3'b011, 0, mk(4'b0100, 2, 1, 1, 0, 0, 0, 0));
        step("m_v001",     0, 0, 1, 3'b001, 0, mk(4'b0010, 3, 2, 1, 0, 0, 0, 0));
        step("m_rst",      1, 1, 1, 3'b111, 1, mk(4'b0000, 0, 0, 0, 0, 0, 0, 0));
        step("m_idle_vv",  0, 0, 1, 3'b111, 0, mk(4'b0000, 0, 0, 0, 0, 0, 0, 0));

        // Close with no ballots: 0 > 0 false, 0 == 0 tie
        step("z_start",    0, 1, 0, 3'b000, 0, mk(4'b0000, 0, 0, 1, 0, 0, 0, 0));
        step("z_close",    0, 0, 0, 3'b000, 1, mk(4'b0000, 0, 0, 0, 1, 0, 0, 1));
        step("z_rst",      1, 0, 0, 3'b000, 0, mk(4'b0000, 0, 0, 0, 0, 0, 0, 0));

        @(negedge clk);
        rst = 1'b0; start = 1'b0; v_valid = 1'b0; v = '0; close = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        n_checks = n_checks + 1;
        if (sb.size() != 0) begin
            n_errors = n_errors + 1;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
